inverse_permutation_func: RTL
=============================

INVERSE_PERMUTATION_FUNC -- requirements
Module: inverse_permutation_func

Interface
REQ-001 Parameter NSLICE, default 64: number of 25-bit slices per frame.
REQ-002 Parameter CNT_W, default 6: slice counter width; SHALL equal clog2(NSLICE).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-006 in_valid  input  1  in_data holds a valid permuted slice.
REQ-007 in_ready  output  1  block can accept a slice this cycle.
REQ-008 in_data  input  25  permuted slice; bit index i = 5*y + x, with x and y in 0..4.
REQ-009 out_valid  output  1  out_data holds a valid restored slice.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  25  restored (inverse-permuted) slice.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the last slice of a frame is accepted downstream.

Function
REQ-014 The inverse mapping SHALL be out(x,y) = in(y, (2x+3y) mod 5), so that applying the team's forward lane swap to it returns the original slice.
REQ-015 States SHALL be IDLE, RECV, PERM, SEND and DONE.
REQ-016 IDLE transitions:
- start=1 -> RECV, and slice counter cleared to 0.
- start=0 -> remain in IDLE.
REQ-017 RECV behaviour:
- in_ready=1.
- in_valid=1 -> capture in_data into the slice register, go to PERM.
- Otherwise remain in RECV.
REQ-018 PERM behaviour:
- Load inv_swap(slice register) into the output register.
- Go to SEND unconditionally (one cycle).
REQ-019 SEND behaviour:
- out_valid=1.
- out_ready=1 and counter = NSLICE-1 -> DONE.
- out_ready=1 otherwise -> increment counter, go to RECV.
- out_ready=0 -> stay in SEND.
REQ-020 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-021 Latency: a slice accepted on edge N SHALL be presented with out_valid=1 from cycle N+2.
REQ-022 in_ready SHALL be 0 in every state except RECV; in_data SHALL be ignored whenever in_ready=0.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-024 A start asserted while busy=1 SHALL be ignored and SHALL NOT restart the counter.
REQ-025 The counter SHALL NOT wrap inside a frame; the frame ends at NSLICE-1, and the counter is cleared only by reset or by the next start in IDLE.
REQ-026 If in_valid and start are asserted in the same IDLE cycle, in_data SHALL NOT be captured; capture begins in RECV.
REQ-027 The block SHALL be fully synthesizable, with no file I/O.

Reset
REQ-028 When rst=1 at a clock edge, the following SHALL all take effect on that edge, overriding all other inputs:
- state -> IDLE
- counter -> 0
- slice and output registers -> 0
- outputs: in_ready=0, out_valid=0, out_data=0, busy=0, done=0
REQ-029 A reset asserted mid-frame SHALL abort the frame with no done pulse; the next frame SHALL restart at slice 0.

Structure
REQ-030 The shared package SHALL hold LANE_W=25, the default NSLICE=64, and the state encoding constants.
REQ-031 The inverse mapping SHALL be one combinational sub-module, inv_swap, with 25-bit input_line and 25-bit output_line.
REQ-032 The counter and FSM SHALL reside in inverse_permutation_func; the implementation SHALL total 120-400 lines of RTL.

Verification
REQ-033 Bit routing:
- in_data=25'h0000002 -> out_data=25'h0000040 (bit (1,0) -> (1,1)).
- in_data=25'h0000001 -> out_data=25'h0000001.
REQ-034 Round trip: 64 random slices passed through the forward swap and then this block -> all 64 match the originals, and done pulses exactly once, one cycle after the 64th out_valid&out_ready.
REQ-035 Backpressure: out_ready held 0 for 5 cycles on slice 3 -> out_data stable, in_ready=0, no slice lost; counter reaches 63 at frame end.
REQ-036 Latency: in_valid=1 in RECV at edge N -> out_valid=1 at cycle N+2 with the correct data.
REQ-037 Reset after slice 10 of a frame -> all outputs 0 on the next cycle; a new start processes 64 slices from slice 0 and pulses done once.
REQ-038 start pulsed at slice 20 of a frame -> ignored; done occurs after slice 63 only.

Source files
------------

// File: rtl/inverse_permutation_func_pkg.sv
// Shared constants and state encoding for the inverse lane-permutation block.
package inverse_permutation_func_pkg;

    // Width of one slice: a 5x5 plane, bit index i = 5*y + x.
    localparam int LANE_W     = 25;
    // Default number of slices in one frame.
    localparam int NSLICE_DEF = 64;

    // Frame-processing FSM states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        PERM = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/inverse_permutation_func_inv_swap.sv
// Purely combinational inverse lane swap for one 5x5 slice:
// out(x,y) = in(y, (2x+3y) mod 5), which undoes the forward swap
// out(y, 2x+3y) = in(x,y).
module inv_swap
    import inverse_permutation_func_pkg::*;
(
    input  logic [LANE_W-1:0] input_line,
    output logic [LANE_W-1:0] output_line
);

    // Fixed wiring; every output bit is a copy of exactly one input bit.
    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar x = 0; x < 5; x++) begin : g_x
            assign output_line[5*y + x] = input_line[5*((2*x + 3*y) % 5) + y];
        end
    end

endmodule

// File: rtl/inverse_permutation_func.sv
// Frame sequencer for the inverse permutation: receives one slice, restores
// it through inv_swap, presents it downstream, repeats for NSLICE slices and
// pulses done after the last one is accepted.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is only high in RECV; out_valid is only high in SEND and
// out_data is held stable there until out_ready is seen.
module inverse_permutation_func
    import inverse_permutation_func_pkg::*;
#(
    parameter int NSLICE = NSLICE_DEF,
    parameter int CNT_W  = 6
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state,
    output logic [CNT_W-1:0]  dbg_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [LANE_W-1:0]   slice_q, slice_n;
    logic [LANE_W-1:0]   out_q, out_n;
    logic [LANE_W-1:0]   perm_w;

    inv_swap u_inv_swap (
        .input_line  (slice_q),
        .output_line (perm_w)
    );

    // State, counter, slice and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slice_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            slice_q <= slice_n;
            out_q   <= out_n;
        end
    end

    // Next-state and datapath update; start is only looked at in IDLE, so a
    // start during a frame cannot disturb the counter.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        slice_n = slice_q;
        out_n   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = RECV;
                    cnt_n   = '0;
                end
            end
            RECV: begin
                if (in_valid) begin
                    slice_n = in_data;
                    state_n = PERM;
                end
            end
            PERM: begin
                out_n   = perm_w;
                state_n = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        state_n = DONE;
                    end else begin
                        cnt_n   = cnt_q + CNT_W'(1);
                        state_n = RECV;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == RECV);
    assign out_valid = (state_q == SEND);
    assign out_data  = out_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule
